ysyx_22051468_muldiv_ctrl: RTL and testbench

Sequencer for the RV64M multiply/divide resource in the execute stage. It takes a decoded M-extension op (is_mul/is_div/is_rem/is_W plus funct3) and its operands through a valid/ready handshake. It runs an iterative radix-2 shift-add multiply or restoring divide, applies sign fix-up and special cases, and holds the result until the writeback side accepts it. The busy output drives the hazard unit's EX stall.

---
 rtl/ysyx_22051468_muldiv_ctrl_pkg.sv | 40 ++++
 rtl/ysyx_22051468_muldiv_iter.sv | 42 ++++
 rtl/ysyx_22051468_muldiv_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_ysyx_22051468_muldiv_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22051468_muldiv_ctrl_pkg.sv
// Shared definitions for the RV64M multiply/divide sequencer: datapath width,
// M-extension funct3 codes, FSM state and result-select encodings, and small
// 32-bit extension helpers used for the *W variants.
package ysyx_22051468_muldiv_ctrl_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned CntW = $clog2(XLEN);

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;
  localparam logic [2:0] F3Remu   = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFixup,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    SelMulLo,
    SelMulHi,
    SelQuo,
    SelRem
  } sel_e;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    return {{(XLEN-32){x[31]}}, x[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
    return {{(XLEN-32){1'b0}}, x[31:0]};
  endfunction

endpackage

// File: rtl/ysyx_22051468_muldiv_iter.sv
// One combinational radix-2 step of the iterative multiply/divide, MSB first.
//   div_i  : 1 = restoring-divide step, 0 = shift-add multiply step
//   bit_i  : current multiplier bit (mul) or next dividend bit (div)
//   opnd_i : multiplicand (mul) or divisor (div) magnitude
//   prod_i/prod_o : 2*XLEN product accumulator
//   rem_i/rem_o   : XLEN+1 partial remainder
//   quo_i/quo_o   : quotient being assembled
module ysyx_22051468_muldiv_iter
  import ysyx_22051468_muldiv_ctrl_pkg::*;
(
  input  logic              div_i,
  input  logic              bit_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic [2*XLEN-1:0] prod_i,
  input  logic [XLEN:0]     rem_i,
  input  logic [XLEN-1:0]   quo_i,
  output logic [2*XLEN-1:0] prod_o,
  output logic [XLEN:0]     rem_o,
  output logic [XLEN-1:0]   quo_o
);

  logic [XLEN+1:0] trial;
  logic [XLEN-1:0] addend;
  logic            qbit;

  always_comb begin
    prod_o = prod_i;
    rem_o  = rem_i;
    quo_o  = quo_i;
    addend = bit_i ? opnd_i : {XLEN{1'b0}};
    // Shift the next dividend bit into the partial remainder, then trial-subtract.
    trial  = {rem_i, bit_i};
    qbit   = (trial >= {2'b00, opnd_i});
    if (div_i) begin
      rem_o = qbit ? (trial[XLEN:0] - {1'b0, opnd_i}) : trial[XLEN:0];
      quo_o = (quo_i << 1) | {{(XLEN-1){1'b0}}, qbit};
    end else begin
      prod_o = (prod_i << 1) + {{XLEN{1'b0}}, addend};
    end
  end

endmodule

// File: rtl/ysyx_22051468_muldiv_ctrl.sv
// RV64M multiply/divide sequencer for the execute stage.
// Accepts a decoded M-extension op over in_valid/in_ready, runs an unsigned
// radix-2 multiply or restoring divide on operand magnitudes, fixes up signs,
// and holds the result in DONE until out_ready. busy stalls EX.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : op handshake (ready only in IDLE)
//   is_mul/div/rem/is_W : decoded op class and 32-bit variant
//   funct3              : M-extension funct3 (signedness / high-half select)
//   src1, src2          : operands
//   flush               : cancel any op in flight
//   out_valid/out_ready : result handshake
//   result              : registered result
//   busy                : state != IDLE
module ysyx_22051468_muldiv_ctrl
  import ysyx_22051468_muldiv_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_mul,
  input  logic            is_div,
  input  logic            is_rem,
  input  logic            is_W,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] Min64 = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MinW  = {{(XLEN-31){1'b1}}, 31'b0};

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  sel_e                sel_q;
  logic                w_q;
  logic                neg_q;
  logic [XLEN-1:0]     mag1_q, mag2_q;
  logic [2*XLEN-1:0]   prod_q;
  logic [XLEN:0]       rem_q;
  logic [XLEN-1:0]     quo_q;
  logic [XLEN-1:0]     result_q;

  // Decode of the offered op.
  sel_e            dec_sel;
  logic            s1_signed, s2_signed, neg1, neg2, dec_neg;
  logic [XLEN-1:0] op1, op2, mag1, mag2, fast_res;
  logic            div_zero, div_ovf, fast, accept;
  logic [CntW-1:0] first_idx;

  always_comb begin
    dec_sel   = SelMulLo;
    s1_signed = 1'b1;
    s2_signed = 1'b1;
    if (is_mul) begin
      dec_sel   = (funct3 == F3Mul) ? SelMulLo : SelMulHi;
      s1_signed = (funct3 != F3Mulhu);
      s2_signed = (funct3 == F3Mul) || (funct3 == F3Mulh);
    end else begin
      dec_sel   = is_div ? SelQuo : SelRem;
      // divu/remu have funct3[0] set
      s1_signed = ~funct3[0];
      s2_signed = ~funct3[0];
    end
    op1 = is_W ? (s1_signed ? sext32(src1) : zext32(src1)) : src1;
    op2 = is_W ? (s2_signed ? sext32(src2) : zext32(src2)) : src2;
    neg1 = s1_signed & op1[XLEN-1];
    neg2 = s2_signed & op2[XLEN-1];
    mag1 = neg1 ? -op1 : op1;
    mag2 = neg2 ? -op2 : op2;
    // Remainder takes the dividend's sign; product and quotient the XOR.
    dec_neg = (dec_sel == SelRem) ? neg1 : (neg1 ^ neg2);

    div_zero = (op2 == '0);
    div_ovf  = s1_signed & (op1 == (is_W ? MinW : Min64)) & (op2 == '1);
    fast     = ~is_mul & (div_zero | div_ovf);
    if (div_zero) begin
      fast_res = (dec_sel == SelQuo) ? '1 : op1;
    end else begin
      fast_res = (dec_sel == SelQuo) ? op1 : '0;
    end
    if (is_W) begin
      fast_res = sext32(fast_res);
    end

    first_idx = is_W ? CntW'(31) : CntW'(XLEN - 1);
    accept    = in_valid & (state_q == StIdle) & (is_mul | is_div | is_rem) & ~flush;
  end

  // The accept edge performs the MSB step directly from the fresh magnitudes,
  // so CALC only needs N-1 further cycles and cnt_q is the next bit index.
  logic              it_div, it_bit;
  logic [XLEN-1:0]   it_a, it_b, it_opnd, it_quo, it_quo_o;
  logic [CntW-1:0]   it_idx;
  logic [2*XLEN-1:0] it_prod, it_prod_o;
  logic [XLEN:0]     it_rem, it_rem_o;

  always_comb begin
    if (state_q == StIdle) begin
      it_div  = ~is_mul;
      it_a    = mag1;
      it_b    = mag2;
      it_idx  = first_idx;
      it_prod = '0;
      it_rem  = '0;
      it_quo  = '0;
    end else begin
      it_div  = (sel_q == SelQuo) || (sel_q == SelRem);
      it_a    = mag1_q;
      it_b    = mag2_q;
      it_idx  = cnt_q;
      it_prod = prod_q;
      it_rem  = rem_q;
      it_quo  = quo_q;
    end
    it_bit  = it_div ? it_a[it_idx] : it_b[it_idx];
    it_opnd = it_div ? it_b : it_a;
  end

  ysyx_22051468_muldiv_iter u_iter (
    .div_i  (it_div),
    .bit_i  (it_bit),
    .opnd_i (it_opnd),
    .prod_i (it_prod),
    .rem_i  (it_rem),
    .quo_i  (it_quo),
    .prod_o (it_prod_o),
    .rem_o  (it_rem_o),
    .quo_o  (it_quo_o)
  );

  // Sign fix-up and result selection.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_mag, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_q ? -prod_q : prod_q;
    quo_fix  = neg_q ? -quo_q : quo_q;
    rem_mag  = rem_q[XLEN-1:0];
    rem_fix  = neg_q ? -rem_mag : rem_mag;
    fix_res  = '0;
    unique case (sel_q)
      SelMulLo: fix_res = prod_fix[XLEN-1:0];
      SelMulHi: fix_res = prod_fix[2*XLEN-1:XLEN];
      SelQuo:   fix_res = quo_fix;
      SelRem:   fix_res = rem_fix;
      default:  fix_res = '0;
    endcase
    if (w_q) begin
      fix_res = sext32(fix_res);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sel_q    <= SelMulLo;
      w_q      <= 1'b0;
      neg_q    <= 1'b0;
      mag1_q   <= '0;
      mag2_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            sel_q  <= dec_sel;
            w_q    <= is_W;
            neg_q  <= dec_neg;
            mag1_q <= mag1;
            mag2_q <= mag2;
            if (fast) begin
              result_q <= fast_res;
              state_q  <= StDone;
            end else begin
              prod_q  <= it_prod_o;
              rem_q   <= it_rem_o;
              quo_q   <= it_quo_o;
              cnt_q   <= first_idx - CntW'(1);
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          prod_q <= it_prod_o;
          rem_q  <= it_rem_o;
          quo_q  <= it_quo_o;
          if (cnt_q == '0) begin
            state_q <= StFixup;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StFixup: begin
          result_q <= fix_res;
          state_q  <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22051468_muldiv_ctrl.sv
// Self-checking bench for ysyx_22051468_muldiv_ctrl: directed cases plus
// randomized ops compared against an arithmetic reference model.
module tb_ysyx_22051468_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_mul = 1'b0;
  logic        is_div = 1'b0;
  logic        is_rem = 1'b0;
  logic        is_W = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22051468_muldiv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_mul    (is_mul),
    .is_div    (is_div),
    .is_rem    (is_rem),
    .is_W      (is_W),
    .funct3    (funct3),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Reference: plain RISC-V M semantics, plus the expected latency.
  function automatic void model(input logic m, input logic d, input logic w,
                                input logic [2:0] f3, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] res,
                                output int lat);
    logic [127:0] pa, pb, p;
    logic [31:0]  a32, b32, q32, r32, p32;
    logic [63:0]  q64, r64;
    logic         sgn, special;
    a32 = a[31:0];
    b32 = b[31:0];
    if (m) begin
      lat = w ? 33 : 65;
      if (w) begin
        p32 = a32 * b32;
        res = sx32(p32);
      end else begin
        pa  = (f3 == 3'b011) ? {64'd0, a} : {{64{a[63]}}, a};
        pb  = (f3 == 3'b010 || f3 == 3'b011) ? {64'd0, b} : {{64{b[63]}}, b};
        p   = pa * pb;
        res = (f3 == 3'b000) ? p[63:0] : p[127:64];
      end
      return;
    end
    sgn = ~f3[0];
    if (w) begin
      special = 1'b1;
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else begin
        special = 1'b0;
        if (sgn) begin
          q32 = $signed(a32) / $signed(b32);
          r32 = $signed(a32) % $signed(b32);
        end else begin
          q32 = a32 / b32;
          r32 = a32 % b32;
        end
      end
      res = d ? sx32(q32) : sx32(r32);
      lat = special ? 1 : 33;
    end else begin
      special = 1'b1;
      if (b == 64'd0) begin
        q64 = '1; r64 = a;
      end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q64 = a; r64 = 64'd0;
      end else begin
        special = 1'b0;
        if (sgn) begin
          q64 = $signed(a) / $signed(b);
          r64 = $signed(a) % $signed(b);
        end else begin
          q64 = a / b;
          r64 = a % b;
        end
      end
      res = d ? q64 : r64;
      lat = special ? 1 : 65;
    end
  endfunction

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(0, 20));
      4:       return 64'hFFFF_FFFF_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Offers an op for one cycle, then scrambles the inputs.
  task automatic launch(input logic m, input logic d, input logic r, input logic w,
                        input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1;
    is_mul = m; is_div = d; is_rem = r; is_W = w;
    funct3 = f3; src1 = a; src2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    src1 = {$urandom, $urandom};
    src2 = {$urandom, $urandom};
    funct3 = 3'($urandom);
    is_W = 1'($urandom);
  endtask

  task automatic run_op(input string tag, input logic m, input logic d, input logic r,
                        input logic w, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] b, input int stall);
    logic [63:0] exp;
    int          exp_lat;
    int          lat;
    model(m, d, w, f3, a, b, exp, exp_lat);
    check({tag, ":in_ready"}, 64'(in_ready), 64'd1);
    launch(m, d, r, w, f3, a, b);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ":result"}, result, exp);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, ":hold_result"}, result, exp);
      check({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ":hold_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, ":hold_busy"}, 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ":consumed"}, 64'(out_valid), 64'd0);
    check({tag, ":idle"}, 64'(in_ready), 64'd1);
  endtask

  task automatic watch_silent(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic       m, d, r, w;
    logic [2:0] f3;
    int         kind;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset:in_ready", 64'(in_ready), 64'd1);
    check("reset:busy", 64'(busy), 64'd0);
    check("reset:out_valid", 64'(out_valid), 64'd0);
    check("reset:result", result, 64'd0);

    // Directed cases
    run_op("mul7x-3", 1, 0, 0, 0, 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("mulhu", 1, 0, 0, 0, 3'b011, '1, '1, 0);
    run_op("mulh", 1, 0, 0, 0, 3'b001, '1, '1, 0);
    run_op("mulhsu", 1, 0, 0, 0, 3'b010, '1, '1, 0);
    run_op("div-20/6", 0, 1, 0, 0, 3'b100, -64'sd20, 64'd6, 0);
    run_op("rem-20/6", 0, 0, 1, 0, 3'b110, -64'sd20, 64'd6, 0);
    run_op("divu0", 0, 1, 0, 0, 3'b101, 64'h1234_5678_9ABC_DEF0, 64'd0, 0);
    run_op("remu0", 0, 0, 1, 0, 3'b111, 64'h1234_5678_9ABC_DEF0, 64'd0, 0);
    run_op("div_ovf", 0, 1, 0, 0, 3'b100, 64'h8000_0000_0000_0000, '1, 0);
    run_op("rem_ovf", 0, 0, 1, 0, 3'b110, 64'h8000_0000_0000_0000, '1, 0);
    run_op("remuw", 0, 0, 1, 1, 3'b111, 64'hFFFF_FFFF_0000_000A, 64'd3, 0);
    run_op("divw_ovf", 0, 1, 0, 1, 3'b100, 64'h0000_0000_8000_0000, '1, 0);
    run_op("mulw", 1, 0, 0, 1, 3'b000, 64'h0000_0001_7FFF_FFFF, 64'd2, 0);
    run_op("backpressure", 1, 0, 0, 0, 3'b000, 64'd123456789, 64'd987654321, 10);

    // Non-M op is ignored
    in_valid = 1'b1; is_mul = 0; is_div = 0; is_rem = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("nonM:busy", 64'(busy), 64'd0);

    // Flush blocks a same-cycle accept
    in_valid = 1'b1; is_mul = 1; funct3 = 3'b000; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept:busy", 64'(busy), 64'd0);

    // Flush mid-CALC
    launch(1, 0, 0, 0, 3'b000, 64'hDEAD_BEEF_0123_4567, 64'h0FED_CBA9_8765_4321);
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush:busy", 64'(busy), 64'd0);
    check("flush:in_ready", 64'(in_ready), 64'd1);
    watch_silent("flush:no_out_valid");
    run_op("after_flush", 1, 0, 0, 0, 3'b000, 64'd3, 64'd5, 0);

    // Reset mid-CALC
    launch(0, 1, 0, 0, 3'b101, 64'hFFFF_0000_FFFF_0000, 64'd12345);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:result", result, 64'd0);
    watch_silent("rst:no_out_valid");
    run_op("after_rst", 1, 0, 0, 0, 3'b000, 64'd3, 64'd5, 0);

    // out_ready together with flush in DONE still returns to IDLE
    launch(0, 1, 0, 0, 3'b101, 64'd99, 64'd0);
    check("done_flush:valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; flush = 1'b0;
    check("done_flush:out_valid", 64'(out_valid), 64'd0);
    check("done_flush:in_ready", 64'(in_ready), 64'd1);

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      m = 0; d = 0; r = 0; w = 0; f3 = 3'b000;
      case (kind)
        0: begin m = 1; f3 = 3'($urandom_range(0, 3)); end
        1: begin m = 1; w = 1; end
        2: begin d = 1; w = 1'($urandom_range(0, 1)); f3 = {2'b10, 1'($urandom_range(0, 1))}; end
        default: begin
          r = 1; w = 1'($urandom_range(0, 1)); f3 = {2'b11, 1'($urandom_range(0, 1))};
        end
      endcase
      run_op("rand", m, d, r, w, f3, rnd_opnd(), rnd_opnd(), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
